// File: rtl/harvest_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// harvest_arbiter_pkg
// Shared definitions for the harvest arbiter: FSM state encoding, the header
// byte that announces each harvest, and the pointer-width helper.
// -----------------------------------------------------------------------------
package harvest_arbiter_pkg;

    // State encoding, kept as named constants so the enum and any debug
    // tooling agree on the raw values.
    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_PAUSE  = 3'd1;
    localparam logic [2:0] ENC_START  = 3'd2;
    localparam logic [2:0] ENC_HEADER = 3'd3;
    localparam logic [2:0] ENC_STREAM = 3'd4;
    localparam logic [2:0] ENC_DONE   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_PAUSE  = ENC_PAUSE,
        ST_START  = ENC_START,
        ST_HEADER = ENC_HEADER,
        ST_STREAM = ENC_STREAM,
        ST_DONE   = ENC_DONE
    } state_t;

    // Header byte; the low bits carry the index of the harvested source.
    localparam logic [7:0] HEADER_BYTE = 8'hA0;

    // Width of the round-robin pointer for a given source count (at least 1).
    function automatic int ptr_width(input int num_src);
        return (num_src > 2) ? $clog2(num_src) : 1;
    endfunction

endpackage : harvest_arbiter_pkg

// File: rtl/harvest_rr_ptr.sv
// -----------------------------------------------------------------------------
// harvest_rr_ptr
// Round-robin source pointer. Advances by one on 'advance', wrapping from
// NUM_SRC-1 back to 0.
//   clk_sys     in   system clock
//   arst_sys_n  in   asynchronous active-low reset (pointer -> 0)
//   advance     in   step to the next source this cycle
//   ptr         out  current source index
// -----------------------------------------------------------------------------
module harvest_rr_ptr #(
    parameter int NUM_SRC = 4,
    parameter int PTR_W   = 2
) (
    input  logic             clk_sys,
    input  logic             arst_sys_n,
    input  logic             advance,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_SRC - 1);

    // NOTE: sequential state is always assigned with <=, so every flop samples
    // the pre-edge values of its neighbours regardless of block ordering.
    always_ff @(posedge clk_sys or negedge arst_sys_n) begin
        if (!arst_sys_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule : harvest_rr_ptr

// File: rtl/harvest_arbiter.sv
// -----------------------------------------------------------------------------
// harvest_arbiter
// Round-robin arbiter that periodically asks each stream grabber for its
// captured data and merges the dumps into one byte stream, each dump preceded
// by a header byte (8'hA0 | source index).
//   clk_sys         in   system clock
//   arst_sys_n      in   asynchronous active-low reset
//   enable          in   permit new harvests (current harvest always finishes)
//   src_start       out  one-hot harvest request per grabber
//   src_reporting   in   grabber is dumping data
//   src_dout        in   byte per grabber, source k at [8k+7:8k]
//   src_dout_valid  in   per-source byte valid
//   src_dout_ready  out  per-source byte ready (only the selected source)
//   out_dat         out  merged byte stream
//   out_valid       out  merged stream valid
//   out_ready       in   merged stream ready
//   cur_src         out  index of the source being serviced
//   busy            out  high in every state except IDLE
//   timeout_err     out  sticky per-source "start never acknowledged"
// -----------------------------------------------------------------------------
module harvest_arbiter
    import harvest_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int PAUSE_BITS = 5,
    parameter int TO_BITS    = 8
) (
    input  logic                 clk_sys,
    input  logic                 arst_sys_n,
    input  logic                 enable,
    output logic [NUM_SRC-1:0]   src_start,
    input  logic [NUM_SRC-1:0]   src_reporting,
    input  logic [8*NUM_SRC-1:0] src_dout,
    input  logic [NUM_SRC-1:0]   src_dout_valid,
    output logic [NUM_SRC-1:0]   src_dout_ready,
    output logic [7:0]           out_dat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           cur_src,
    output logic                 busy,
    output logic [NUM_SRC-1:0]   timeout_err
);

    localparam int PTR_W = ptr_width(NUM_SRC);

    state_t                state, state_nxt;
    logic [PAUSE_BITS-1:0] pause_cnt, pause_cnt_nxt;
    logic [TO_BITS-1:0]    to_cnt, to_cnt_nxt;
    logic [NUM_SRC-1:0]    timeout_err_nxt;
    logic [1:0]            rst_sync;
    logic                  run_ok;
    logic [PTR_W-1:0]      ptr;
    logic                  advance;
    logic [NUM_SRC-1:0]    ptr_onehot;
    logic                  sel_reporting;
    logic                  sel_valid;
    logic [7:0]            sel_dout;

    // NOTE: reset asserts asynchronously but is released through two flops, so
    // the FSM only leaves IDLE on a clean, clock-aligned release.
    always_ff @(posedge clk_sys or negedge arst_sys_n) begin
        if (!arst_sys_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign run_ok = rst_sync[1];

    harvest_rr_ptr #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_rr_ptr (
        .clk_sys    (clk_sys),
        .arst_sys_n (arst_sys_n),
        .advance    (advance),
        .ptr        (ptr)
    );

    // Select the serviced source's signals. Unselected sources never reach
    // the output path.
    always_comb begin
        ptr_onehot    = '0;
        sel_reporting = 1'b0;
        sel_valid     = 1'b0;
        sel_dout      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (PTR_W'(k) == ptr) begin
                ptr_onehot[k] = 1'b1;
                sel_reporting = src_reporting[k];
                sel_valid     = src_dout_valid[k];
                sel_dout      = src_dout[8*k +: 8];
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt       = state;
        pause_cnt_nxt   = pause_cnt;
        to_cnt_nxt      = to_cnt;
        timeout_err_nxt = timeout_err;
        advance         = 1'b0;
        src_start       = '0;
        src_dout_ready  = '0;
        out_valid       = 1'b0;
        out_dat         = '0;

        case (state)
            ST_IDLE: begin
                if (enable && run_ok) begin
                    state_nxt     = ST_PAUSE;
                    pause_cnt_nxt = '0;
                end
            end

            // enable is only re-examined at the end of the pause.
            ST_PAUSE: begin
                if (pause_cnt == '1) begin
                    to_cnt_nxt = '0;
                    state_nxt  = enable ? ST_START : ST_IDLE;
                end else begin
                    pause_cnt_nxt = pause_cnt + 1'b1;
                end
            end

            ST_START: begin
                src_start = ptr_onehot;
                if (sel_reporting) begin
                    state_nxt = ST_HEADER;
                end else if (to_cnt == '1) begin
                    timeout_err_nxt = timeout_err | ptr_onehot;
                    state_nxt       = ST_DONE;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end

            ST_HEADER: begin
                out_valid = 1'b1;
                out_dat   = HEADER_BYTE | 8'(ptr);
                if (out_ready) begin
                    state_nxt = ST_STREAM;
                end
            end

            // Pure combinational pass-through; holding data stable while
            // stalled is the grabber's side of the handshake.
            ST_STREAM: begin
                out_valid      = sel_valid;
                out_dat        = sel_dout;
                src_dout_ready = ptr_onehot & {NUM_SRC{out_ready}};
                if (!sel_reporting && !sel_valid) begin
                    state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                advance = 1'b1;
                if (enable) begin
                    state_nxt     = ST_PAUSE;
                    pause_cnt_nxt = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge arst_sys_n) begin
        if (!arst_sys_n) begin
            state       <= ST_IDLE;
            pause_cnt   <= '0;
            to_cnt      <= '0;
            timeout_err <= '0;
        end else begin
            state       <= state_nxt;
            pause_cnt   <= pause_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    assign busy    = (state != ST_IDLE);
    assign cur_src = 3'(ptr);

endmodule : harvest_arbiter

// File: tb/tb_harvest_arbiter.sv
// -----------------------------------------------------------------------------
// tb_harvest_arbiter
// Bench for harvest_arbiter: a 4-source instance driven by behavioural
// grabbers with a byte scoreboard, plus a 3-source instance for pointer wrap.
// -----------------------------------------------------------------------------
module tb_harvest_arbiter;

    localparam int         N   = 4;
    localparam int         LEN = 3;
    localparam logic [7:0] HDR = 8'hA0;

    typedef struct {
        int           wait_starts;
        logic [N-1:0] silent;
        int           ready_mode;
        logic [N-1:0] exp_terr;
        logic [2:0]   exp_cur;
    } phase_t;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // 4-source DUT
    logic           arst_sys_n;
    logic           enable;
    logic [N-1:0]   src_start, src_reporting, src_dout_valid, src_dout_ready, timeout_err;
    logic [8*N-1:0] src_dout;
    logic [7:0]     out_dat;
    logic           out_valid, out_ready;
    logic [2:0]     cur_src;
    logic           busy;

    harvest_arbiter #(.NUM_SRC(N), .PAUSE_BITS(5), .TO_BITS(8)) dut (
        .clk_sys        (clk_sys),
        .arst_sys_n     (arst_sys_n),
        .enable         (enable),
        .src_start      (src_start),
        .src_reporting  (src_reporting),
        .src_dout       (src_dout),
        .src_dout_valid (src_dout_valid),
        .src_dout_ready (src_dout_ready),
        .out_dat        (out_dat),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .cur_src        (cur_src),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    // 3-source DUT: grabbers acknowledge instantly and report nothing.
    logic        enable3;
    logic [2:0]  src_start3, src_dout_ready3, timeout_err3;
    logic [23:0] src_dout3;
    logic [2:0]  src_dout_valid3;
    logic [7:0]  out_dat3;
    logic        out_valid3, out_ready3;
    logic [2:0]  cur_src3;
    logic        busy3;

    assign src_dout3       = '0;
    assign src_dout_valid3 = '0;
    assign out_ready3      = 1'b1;

    harvest_arbiter #(.NUM_SRC(3), .PAUSE_BITS(5), .TO_BITS(8)) dut3 (
        .clk_sys        (clk_sys),
        .arst_sys_n     (arst_sys_n),
        .enable         (enable3),
        .src_start      (src_start3),
        .src_reporting  (src_start3),
        .src_dout       (src_dout3),
        .src_dout_valid (src_dout_valid3),
        .src_dout_ready (src_dout_ready3),
        .out_dat        (out_dat3),
        .out_valid      (out_valid3),
        .out_ready      (out_ready3),
        .cur_src        (cur_src3),
        .busy           (busy3),
        .timeout_err    (timeout_err3)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gbyte(input int k, input int i);
        return 8'(16 * (k + 1) + i);
    endfunction

    // Grabber model and scoreboard state
    logic [N-1:0] g_active = '0;
    int           g_idx[N];
    logic [N-1:0] silent = '0;
    int           ready_mode = 0;      // 0: ready high, 1: toggle, 2: ready low
    logic [7:0]   sb[$];
    logic         in_stream = 1'b0;
    logic         stalled = 1'b0;
    logic [7:0]   stall_dat = '0;
    int           exp_src = 0;
    int           start_src = 0;
    logic         start_silent = 1'b0;
    int           start_len = 0;
    int           start_cnt = 0;
    logic [N-1:0] prev_start = '0;
    int           gap_cnt = 0;
    logic         gap_valid = 1'b0;
    logic [2:0]   prev_cur = '0;
    int           hdr_cnt = 0;
    logic [7:0]   last_hdr = '0;

    // Per cycle: drive grabber inputs on the falling edge, then sample 1 time
    // unit later; the values sampled here are what the next rising edge sees.
    always @(negedge clk_sys) begin
        logic         xfer;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_oh;

        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
        for (int k = 0; k < N; k++) begin
            if (g_active[k]) begin
                src_reporting[k]   = 1'b1;
                src_dout_valid[k]  = 1'b1;
                src_dout[8*k +: 8] = gbyte(k, g_idx[k]);
            end else if (k == int'(cur_src)) begin
                src_reporting[k]   = 1'b0;
                src_dout_valid[k]  = 1'b0;
                src_dout[8*k +: 8] = 8'h00;
            end else begin
                src_reporting[k]   = 1'b0;
                src_dout_valid[k]  = 1'($urandom_range(0, 1));
                src_dout[8*k +: 8] = 8'hEE;
            end
        end

        #1;
        if (!arst_sys_n) begin
            g_active   = '0;
            for (int k = 0; k < N; k++) g_idx[k] = 0;
            in_stream  = 1'b0;
            stalled    = 1'b0;
            exp_src    = 0;
            start_len  = 0;
            prev_start = '0;
            gap_valid  = 1'b0;
            prev_cur   = '0;
            sb.delete();
        end else begin
            xfer = out_valid && out_ready;

            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_dat", 32'(out_dat), 32'(stall_dat));
            end
            stalled   = out_valid && !out_ready;
            stall_dat = out_dat;

            if (xfer) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_byte: got %02h, expected no byte (t=%0t)", out_dat, $time);
                end else begin
                    check("out_byte", 32'(out_dat), 32'(sb.pop_front()));
                end
                if (!in_stream) begin
                    hdr_cnt++;
                    last_hdr = out_dat;
                end
            end

            exp_rdy = '0;
            if (in_stream) exp_rdy[start_src] = out_ready;
            check("src_ready_mirror", 32'(src_dout_ready), 32'(exp_rdy));

            if (in_stream && !src_reporting[start_src] && !src_dout_valid[start_src])
                in_stream = 1'b0;
            else if (xfer && !in_stream)
                in_stream = 1'b1;

            for (int k = 0; k < N; k++) begin
                if (g_active[k] && src_dout_ready[k] && src_dout_valid[k]) begin
                    g_idx[k]++;
                    if (g_idx[k] == LEN) g_active[k] = 1'b0;
                end
            end

            if (!busy) gap_valid = 1'b0;
            if (cur_src != prev_cur) begin
                gap_valid = busy;
                gap_cnt   = 0;
            end

            if (src_start != '0 && prev_start == '0) begin
                exp_oh          = '0;
                exp_oh[exp_src] = 1'b1;
                check("start_onehot", 32'(src_start), 32'(exp_oh));
                if (gap_valid) check("pause_gap", 32'(gap_cnt), 32'd32);
                gap_valid    = 1'b0;
                start_src    = exp_src;
                start_silent = silent[exp_src];
                start_len    = 0;
                start_cnt++;
                if (!silent[exp_src]) begin
                    g_active[exp_src] = 1'b1;
                    g_idx[exp_src]    = 0;
                    sb.push_back(HDR | 8'(exp_src));
                    for (int i = 0; i < LEN; i++) sb.push_back(gbyte(exp_src, i));
                end
                exp_src = (exp_src + 1) % N;
            end
            if (src_start != '0) start_len++;
            if (src_start == '0 && prev_start != '0) begin
                if (start_silent) begin
                    check("start_len_timeout", 32'(start_len), 32'd256);
                    check("timeout_flag", 32'(timeout_err[start_src]), 32'd1);
                end else begin
                    check("start_len_ack", 32'(start_len), 32'd2);
                end
            end
            if (src_start == '0) gap_cnt++;

            prev_cur   = cur_src;
            prev_start = src_start;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_src_start"}, 32'(src_start), 32'd0);
        check({tag, "_src_ready"}, 32'(src_dout_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_dat"}, 32'(out_dat), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_cur_src"}, 32'(cur_src), 32'd0);
    endtask

    initial begin
        phase_t     phases[4];
        logic [2:0] wrap_seq[5];

        phases[0] = '{wait_starts: 1,  silent: 4'b0000, ready_mode: 0, exp_terr: 4'b0000, exp_cur: 3'd0};
        phases[1] = '{wait_starts: 5,  silent: 4'b0100, ready_mode: 1, exp_terr: 4'b0000, exp_cur: 3'd0};
        phases[2] = '{wait_starts: 9,  silent: 4'b0000, ready_mode: 0, exp_terr: 4'b0100, exp_cur: 3'd0};
        phases[3] = '{wait_starts: 10, silent: 4'b0000, ready_mode: 0, exp_terr: 4'b0100, exp_cur: 3'd1};
        wrap_seq  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};

        arst_sys_n = 1'b0;
        enable     = 1'b0;
        enable3    = 1'b1;
        out_ready  = 1'b1;

        repeat (3) @(negedge clk_sys);
        #2;
        check_reset_outputs("reset");
        @(negedge clk_sys);
        arst_sys_n = 1'b1;
        enable     = 1'b1;

        fork
            begin : main_4src
                int c;
                int n;
                for (int p = 0; p < 4; p++) begin
                    c = 0;
                    while (start_cnt < phases[p].wait_starts && c < 3000) begin
                        @(negedge clk_sys);
                        #2;
                        c++;
                    end
                    check("phase_reached", 32'(start_cnt >= phases[p].wait_starts), 32'd1);
                    check("phase_timeout_err", 32'(timeout_err), 32'(phases[p].exp_terr));
                    check("phase_cur_src", 32'(cur_src), 32'(phases[p].exp_cur));
                    silent     = phases[p].silent;
                    ready_mode = phases[p].ready_mode;
                end

                // Drop enable while source 1 is streaming.
                c = 0;
                while (!(in_stream && start_src == 1) && c < 500) begin
                    @(negedge clk_sys);
                    #2;
                    c++;
                end
                check("reach_stream_src1", 32'(in_stream), 32'd1);
                @(negedge clk_sys);
                #2;
                enable = 1'b0;
                c = 0;
                while (busy && c < 500) begin
                    @(negedge clk_sys);
                    #2;
                    c++;
                end
                check("idle_after_drop", 32'(busy), 32'd0);
                check("ptr_after_drop", 32'(cur_src), 32'd2);
                check("src1_bytes_all_out", 32'(sb.size()), 32'd0);
                n = start_cnt;
                repeat (100) @(negedge clk_sys);
                #2;
                check("no_start_when_disabled", 32'(start_cnt), 32'(n));
                check("still_idle", 32'(busy), 32'd0);

                // Reset while a header is held by backpressure.
                ready_mode = 2;
                enable     = 1'b1;
                c = 0;
                while (!out_valid && c < 500) begin
                    @(negedge clk_sys);
                    #2;
                    c++;
                end
                check("held_header", 32'(out_dat), 32'(HDR | 8'd2));
                @(negedge clk_sys);
                arst_sys_n = 1'b0;
                #2;
                check_reset_outputs("midreset");
                repeat (2) @(negedge clk_sys);
                ready_mode = 0;
                n          = hdr_cnt;
                arst_sys_n = 1'b1;
                c = 0;
                while (hdr_cnt == n && c < 500) begin
                    @(negedge clk_sys);
                    #2;
                    c++;
                end
                check("first_header_after_reset", 32'(last_hdr), 32'(HDR));
                enable = 1'b0;
                c = 0;
                while (busy && c < 500) begin
                    @(negedge clk_sys);
                    #2;
                    c++;
                end
                check("final_idle", 32'(busy), 32'd0);
                check("final_sb_empty", 32'(sb.size()), 32'd0);
            end

            begin : wrap_3src
                int         seen;
                int         c;
                logic [2:0] prev3;
                seen  = 0;
                c     = 0;
                prev3 = '0;
                while (seen < 5 && c < 3000) begin
                    @(negedge clk_sys);
                    #2;
                    if (src_start3 != '0 && prev3 == '0) begin
                        check("wrap_cur_src", 32'(cur_src3), 32'(wrap_seq[seen]));
                        seen++;
                    end
                    prev3 = src_start3;
                    c++;
                end
                check("wrap_harvests", 32'(seen), 32'd5);
                enable3 = 1'b0;
            end
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_harvest_arbiter

// File: doc/harvest_arbiter.md
HARVEST_ARBITER -- requirements
Module: harvest_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of stream-grabber sources sharing one byte output channel (2..8).
REQ-002 Parameter PAUSE_BITS, default 5: pause between harvests is 2^PAUSE_BITS clk_sys cycles.
REQ-003 Parameter TO_BITS, default 8: start-acknowledge timeout is 2^TO_BITS clk_sys cycles.
REQ-004 clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-005 arst_sys_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  permits new harvests; low finishes the current harvest, then idles.
REQ-007 src_start  out  NUM_SRC  one-hot harvest request to each grabber.
REQ-008 src_reporting  in  NUM_SRC  grabber is dumping captured data.
REQ-009 src_dout  in  8*NUM_SRC  byte from each grabber, source k at bits [8k+7:8k].
REQ-010 src_dout_valid  in  NUM_SRC  per-source byte valid.
REQ-011 src_dout_ready  out  NUM_SRC  per-source byte ready.
REQ-012 out_dat  out  8  merged byte stream toward the host link.
REQ-013 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-014 cur_src  out  3  index of the source being serviced.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 timeout_err  out  NUM_SRC  sticky per-source flag: start never acknowledged.

Function
REQ-017 States: IDLE, PAUSE, START, HEADER, STREAM, DONE.
REQ-018 IDLE: when enable=1, go to PAUSE with the pause counter cleared.
REQ-019 PAUSE: count up; at terminal count (2^PAUSE_BITS-1) go to START if enable=1, else IDLE.
REQ-020 START: drive src_start[ptr]=1, all other bits 0; when src_reporting[ptr]=1, go to HEADER and drop src_start next cycle.
REQ-021 START timeout: if reporting is absent for 2^TO_BITS cycles, set timeout_err[ptr], drop start, and go to DONE without emitting a header.
REQ-022 HEADER: out_dat=8'hA0|ptr, out_valid=1; hold until out_ready=1, then go to STREAM.
REQ-023 STREAM mux:
- out_dat = src_dout[ptr]; out_valid = src_dout_valid[ptr].
- src_dout_ready[ptr] = out_ready; all other ready bits are 0.
- The path is combinational, with zero added latency.
REQ-024 STREAM exit: when src_reporting[ptr]=0 and no transfer is pending (src_dout_valid[ptr]=0), go to DONE.
REQ-025 DONE, one cycle: ptr = (ptr==NUM_SRC-1) ? 0 : ptr+1; then go to PAUSE if enable=1, else IDLE.
REQ-026 Output handshake: a byte transfers when out_valid and out_ready are both high. Once asserted, out_valid and out_dat stay stable until that transfer.
REQ-027 No byte from a non-selected source ever reaches out_dat. Non-selected valids are ignored.
REQ-028 Outside HEADER and STREAM, out_valid=0 and out_dat=0.
REQ-029 enable falling mid-harvest does not abort START, HEADER or STREAM. It takes effect only at DONE or PAUSE.
REQ-030 Only timeout_err bits are sticky; they clear only on reset.
REQ-031 cur_src = ptr at all times.

Reset
REQ-032 On arst_sys_n=0, immediately:
- state=IDLE, ptr=0, counters=0.
- src_start=0, src_dout_ready=0, out_valid=0, out_dat=0.
- busy=0, timeout_err=0.
REQ-033 Reset asserted mid-harvest abandons the harvest with no flush.
REQ-034 Reset release is synchronised internally (two-flop) before the FSM leaves IDLE.

Structure
REQ-035 A shared package holds:
- the state encoding localparams;
- the header constant 8'hA0;
- the helper function for the ptr width.
REQ-036 One sub-module, harvest_rr_ptr, holds the round-robin pointer with advance/wrap. All other logic stays in harvest_arbiter.

Verification
REQ-037 Round-robin scenario.
- Stimulus: NUM_SRC=4, enable=1, each grabber reports 3 bytes with out_ready=1.
- Required: header bytes A0,A1,A2,A3 in order, each followed by its source's 3 bytes; 32-cycle gap before each src_start.
REQ-038 Timeout scenario.
- Stimulus: source 2 never asserts reporting.
- Required: after 256 START cycles, timeout_err=4'b0100, no A2 header emitted, next start goes to source 3.
REQ-039 Backpressure scenario.
- Stimulus: out_ready toggles 1010… during STREAM.
- Required: every byte appears exactly once, stable while stalled, in order.
- Required: src_dout_ready of the selected source mirrors out_ready; all others stay 0.
REQ-040 Enable-drop scenario.
- Stimulus: enable deasserted during STREAM of source 1.
- Required: source 1 finishes all bytes, DONE advances ptr to 2, FSM goes to IDLE, busy=0, no further src_start.
REQ-041 Mid-harvest reset scenario.
- Stimulus: arst_sys_n pulsed low during HEADER.
- Required: all outputs 0 in the same cycle; after release, the first header is A0.
REQ-042 Wrap scenario.
- Stimulus: NUM_SRC=3, run 5 harvests.
- Required: cur_src sequence 0,1,2,0,1.
